// File: rtl/qtr_array_reader.sv
// Multi-channel QTR RC reflectance reader: one sequencer times every channel's pad decay against a shared counter.
// Latency: SETTLE_CYCLES + CHARGE_CYCLES + decay time + 1 cycles from start to frame_valid; decay result = pad-low cycle + 2.
// No backpressure: start is ignored while busy, results hold until the next frame overwrites them.
module qtr_array_reader #(
  parameter int CHANNELS       = 8,
  parameter int TTD_WIDTH      = 16,
  parameter int CHARGE_CYCLES  = 160,
  parameter int SETTLE_CYCLES  = 3200,
  parameter int TIMEOUT_CYCLES = 40000,
  parameter int CONTINUOUS     = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [CHANNELS-1:0]           channel_en,
  inout  wire  [CHANNELS-1:0]           sensor,
  output logic                          emitter_even,
  output logic                          emitter_odd,
  output logic                          busy,
  output logic                          frame_valid,
  output logic [CHANNELS*TTD_WIDTH-1:0] ttd,
  output logic [CHANNELS-1:0]           timeout_flag
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_CHARGE = 3'd2;
  localparam logic [2:0] S_DECAY  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // One counter serves settle, charge and decay phases, so it must cover the widest of them.
  localparam int  SC_MAX = (SETTLE_CYCLES > CHARGE_CYCLES) ? SETTLE_CYCLES : CHARGE_CYCLES;
  localparam int  SC_W   = $clog2(SC_MAX + 1);
  localparam int  CNT_W  = (SC_W > TTD_WIDTH) ? SC_W : TTD_WIDTH;
  localparam bit  CONT   = (CONTINUOUS != 0);

  logic [2:0]                    state_q, state_nxt;
  logic [CNT_W-1:0]              cnt_q;
  logic [CHANNELS-1:0]           mask_q;
  logic [CHANNELS-1:0]           lat_q, lat_nxt;
  logic [CHANNELS-1:0]           tof_q, tof_nxt;
  logic [CHANNELS*TTD_WIDTH-1:0] val_q, val_nxt;
  logic [CHANNELS-1:0]           sync1_q, sync2_q;
  logic                          begin_frame;
  logic                          any_even, any_odd, emit_phase;

  // A frame begins from IDLE on start (or every cycle in continuous mode), or straight out of DONE in continuous mode.
  assign begin_frame = ((state_q == S_IDLE) && (start || CONT)) || ((state_q == S_DONE) && CONT);

  // Next-state and per-channel latch/timeout decisions.
  always_comb begin
    state_nxt = state_q;
    lat_nxt   = lat_q;
    tof_nxt   = tof_q;
    val_nxt   = val_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (begin_frame) state_nxt = (channel_en == '0) ? S_DONE : S_SETTLE;
        else             state_nxt = S_IDLE;
      end
      S_SETTLE: if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_nxt = S_CHARGE;
      S_CHARGE: if (cnt_q == CNT_W'(CHARGE_CYCLES - 1)) state_nxt = S_DECAY;
      S_DECAY: begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (mask_q[i] && !lat_q[i] && !sync2_q[i]) begin
            lat_nxt[i] = 1'b1;
            val_nxt[i*TTD_WIDTH +: TTD_WIDTH] = cnt_q[TTD_WIDTH-1:0];
          end
        end
        if ((lat_nxt & mask_q) == mask_q) begin
          state_nxt = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          // A channel that latched on this very cycle keeps its measured value and no flag.
          for (int i = 0; i < CHANNELS; i++) begin
            if (mask_q[i] && !lat_nxt[i]) begin
              tof_nxt[i] = 1'b1;
              val_nxt[i*TTD_WIDTH +: TTD_WIDTH] = TTD_WIDTH'(TIMEOUT_CYCLES);
            end
          end
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sequencer state, phase counter, frame-local latches and published results.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      mask_q       <= '0;
      lat_q        <= '0;
      tof_q        <= '0;
      val_q        <= '0;
      ttd          <= '0;
      timeout_flag <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= ((state_nxt != state_q) || (state_q == S_IDLE)) ? '0 : cnt_q + 1'b1;
      if (begin_frame) begin
        mask_q <= channel_en;
        lat_q  <= '0;
        tof_q  <= '0;
        val_q  <= '0;
      end else begin
        lat_q  <= lat_nxt;
        tof_q  <= tof_nxt;
        val_q  <= val_nxt;
      end
      // Results publish on entry to DONE so they are already visible during the frame_valid cycle.
      if ((state_q == S_DECAY) && (state_nxt == S_DONE)) begin
        ttd          <= val_nxt;
        timeout_flag <= tof_nxt;
      end else if (state_nxt == S_DONE) begin
        ttd          <= '0;
        timeout_flag <= '0;
      end
    end
  end

  // Two-flop synchroniser on the released pads; its latency is deliberately left in the result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sensor;
      sync2_q <= sync1_q;
    end
  end

  // Emitter banks only light when at least one channel of that parity is enabled.
  always_comb begin
    any_even = 1'b0;
    any_odd  = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if ((i % 2) == 0) any_even = any_even | mask_q[i];
      else              any_odd  = any_odd  | mask_q[i];
    end
  end

  assign emit_phase   = (state_q == S_SETTLE) || (state_q == S_CHARGE) || (state_q == S_DECAY);
  assign emitter_even = emit_phase && any_even;
  assign emitter_odd  = emit_phase && any_odd;
  assign busy         = (state_q != S_IDLE);
  assign frame_valid  = (state_q == S_DONE);

  // Pads are only ever driven high while charging; otherwise released so the RC decay is observable.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_pad
    assign sensor[g] = ((state_q == S_CHARGE) && mask_q[g]) ? 1'b1 : 1'bz;
  end

endmodule

// File: tb/tb_qtr_array_reader.sv
// Directed bench for qtr_array_reader with an RC pad model and a second free-running continuous instance.
// Latency expectations are hand-derived from settle/charge/decay timing plus the two-cycle synchroniser.
// Pads are modelled as pulled low, held high by the bench until each channel's programmed decay cycle.
module tb_qtr_array_reader;

  localparam int CH  = 4;
  localparam int TW  = 16;
  localparam int SET = 2;
  localparam int CHG = 4;
  localparam int TO  = 100;
  localparam int SC  = SET + CHG;

  logic clk = 1'b0;
  logic reset_n, rst2_n, start;
  logic [CH-1:0] channel_en;
  tri0  [CH-1:0] pad;
  tri0  [CH-1:0] pad2;

  logic             emitter_even, emitter_odd, busy, frame_valid;
  logic [CH*TW-1:0] ttd;
  logic [CH-1:0]    timeout_flag;
  logic             emitter_even2, emitter_odd2, busy2, frame_valid2;
  logic [CH*TW-1:0] ttd2;
  logic [CH-1:0]    timeout_flag2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  qtr_array_reader #(
    .CHANNELS(CH), .TTD_WIDTH(TW), .CHARGE_CYCLES(CHG),
    .SETTLE_CYCLES(SET), .TIMEOUT_CYCLES(TO), .CONTINUOUS(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .channel_en(channel_en),
    .sensor(pad), .emitter_even(emitter_even), .emitter_odd(emitter_odd),
    .busy(busy), .frame_valid(frame_valid), .ttd(ttd), .timeout_flag(timeout_flag)
  );

  qtr_array_reader #(
    .CHANNELS(CH), .TTD_WIDTH(TW), .CHARGE_CYCLES(CHG),
    .SETTLE_CYCLES(SET), .TIMEOUT_CYCLES(TO), .CONTINUOUS(1)
  ) dut_cont (
    .clk(clk), .reset_n(rst2_n), .start(1'b0), .channel_en(4'hF),
    .sensor(pad2), .emitter_even(emitter_even2), .emitter_odd(emitter_odd2),
    .busy(busy2), .frame_valid(frame_valid2), .ttd(ttd2), .timeout_flag(timeout_flag2)
  );

  // Pad model: frame_k counts edges from the start edge; channel i is held high until decay cycle thr[i].
  logic          tracking = 1'b0;
  logic [CH-1:0] tb_mask  = '0;
  int            frame_k  = 0;
  int            thr [CH];
  logic [CH-1:0] hold;

  always @(posedge clk) frame_k <= tracking ? frame_k + 1 : 0;

  always_comb begin
    hold = '0;
    for (int i = 0; i < CH; i++)
      hold[i] = tracking && tb_mask[i] && ((thr[i] < 0) || (frame_k <= SC + thr[i]));
  end

  for (genvar g = 0; g < CH; g++) begin : g_pad
    assign pad[g] = hold[g] ? 1'b1 : 1'bz;
  end

  // Free-running monitors sampled on the falling edge.
  int cyc = 0, busy_tot = 0, fv_tot = 0, eme_tot = 0, emo_tot = 0, hi_tot = 0, fv2_n = 0;
  int         fv2_t  [6];
  logic [63:0] ttd2_c [6];
  logic [2:0]  st2_c  [6];

  always @(negedge clk) begin
    cyc      <= cyc + 1;
    busy_tot <= busy_tot + int'(busy);
    fv_tot   <= fv_tot + int'(frame_valid);
    eme_tot  <= eme_tot + int'(emitter_even);
    emo_tot  <= emo_tot + int'(emitter_odd);
    hi_tot   <= hi_tot + int'(pad[3:2] != 2'b00);
    if (frame_valid2 && fv2_n < 6) begin
      fv2_t[fv2_n]  <= cyc;
      ttd2_c[fv2_n] <= ttd2;
      st2_c[fv2_n]  <= {busy2, emitter_even2, emitter_odd2};
      fv2_n         <= fv2_n + 1;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [3:0] m, input int t0, input int t1, input int t2, input int t3);
    @(negedge clk);
    thr[0] = t0; thr[1] = t1; thr[2] = t2; thr[3] = t3;
    tb_mask    = m;
    channel_en = m;
    start      = 1'b1;
    tracking   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (busy) check_val(tag, 64'(busy), 64'd0);
    tracking = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int b0, f0, e0, o0, h0;

  task automatic snap();
    b0 = busy_tot; f0 = fv_tot; e0 = eme_tot; o0 = emo_tot; h0 = hi_tot;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; rst2_n = 1'b0; start = 1'b0; channel_en = '0;
    for (int i = 0; i < CH; i++) thr[i] = -1;
    repeat (3) @(negedge clk);

    // Reset state
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_fv", 64'(frame_valid), 64'd0);
    check_val("rst_ttd", ttd, 64'd0);
    check_val("rst_flags", 64'(timeout_flag), 64'd0);
    check_val("rst_emit", 64'({emitter_even, emitter_odd}), 64'd0);
    check_val("rst_pad", 64'(pad), 64'd0);
    reset_n = 1'b1; rst2_n = 1'b1;
    @(negedge clk);

    // Basic frame: all channels, decay at 10/20/30/40
    snap();
    launch(4'hF, 10, 20, 30, 40);
    wait_idle("basic_done", 300);
    check_val("basic_ttd", ttd, {16'd42, 16'd32, 16'd22, 16'd12});
    check_val("basic_flags", 64'(timeout_flag), 64'd0);
    check_val("basic_fv", 64'(fv_tot - f0), 64'd1);
    check_val("basic_busy", 64'(busy_tot - b0), 64'd50);

    // Timeout: ch0 at d=5, ch1 never decays, ch2/ch3 disabled
    snap();
    launch(4'b0011, 5, -1, -1, -1);
    wait_idle("to_done", 300);
    check_val("to_ttd", ttd, {16'd0, 16'd0, 16'd100, 16'd7});
    check_val("to_flags", 64'(timeout_flag), 64'b0010);
    check_val("to_pad_idle", 64'(hi_tot - h0), 64'd0);
    check_val("to_busy", 64'(busy_tot - b0), 64'd108);
    check_val("to_emit_even", 64'(eme_tot - e0), 64'd107);
    check_val("to_emit_odd", 64'(emo_tot - o0), 64'd107);

    // Emitter gating: only ch2 enabled
    snap();
    launch(4'b0100, -1, -1, 3, -1);
    wait_idle("emit_done", 300);
    check_val("emit_ttd", ttd, {16'd0, 16'd5, 16'd0, 16'd0});
    check_val("emit_even", 64'(eme_tot - e0), 64'd12);
    check_val("emit_odd", 64'(emo_tot - o0), 64'd0);
    check_val("emit_busy", 64'(busy_tot - b0), 64'd13);

    // Zero mask: straight to DONE
    snap();
    launch(4'b0000, -1, -1, -1, -1);
    wait_idle("zero_done", 20);
    check_val("zero_busy", 64'(busy_tot - b0), 64'd1);
    check_val("zero_fv", 64'(fv_tot - f0), 64'd1);
    check_val("zero_ttd", ttd, 64'd0);

    // Start and mask change mid-frame are ignored
    snap();
    launch(4'b0011, 3, 4, -1, -1);
    repeat (8) @(negedge clk);
    start = 1'b1; channel_en = 4'b0001;
    @(negedge clk);
    start = 1'b0;
    wait_idle("ign_done", 300);
    check_val("ign_ttd", ttd, {16'd0, 16'd0, 16'd6, 16'd5});
    check_val("ign_fv", 64'(fv_tot - f0), 64'd1);
    check_val("ign_busy", 64'(busy_tot - b0), 64'd14);
    repeat (3) @(negedge clk);
    check_val("ign_no_queue", 64'(busy), 64'd0);
    launch(channel_en, 7, 3, -1, -1);
    wait_idle("next_done", 300);
    check_val("next_ttd", ttd, {16'd0, 16'd0, 16'd0, 16'd9});

    // Reset mid-CHARGE: pads must release immediately
    launch(4'hF, 50, 50, 50, 50);
    tb_mask = 4'h0;
    repeat (3) @(negedge clk);
    check_val("charge_drive", 64'(pad), 64'hF);
    reset_n = 1'b0;
    #1;
    check_val("rstc_pad", 64'(pad), 64'd0);
    check_val("rstc_busy", 64'(busy), 64'd0);
    tracking = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Reset mid-DECAY: frame abandoned, results cleared, no frame_valid
    snap();
    launch(4'hF, 50, 50, 50, 50);
    repeat (9) @(negedge clk);
    check_val("pre_rst_emit", 64'({emitter_even, emitter_odd}), 64'b11);
    reset_n = 1'b0; tracking = 1'b0;
    #1;
    check_val("rstd_emit", 64'({emitter_even, emitter_odd}), 64'd0);
    check_val("rstd_busy", 64'(busy), 64'd0);
    check_val("rstd_pad", 64'(pad), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (60) @(negedge clk);
    check_val("post_rst_ttd", ttd, 64'd0);
    check_val("post_rst_fv", 64'(fv_tot - f0), 64'd0);
    check_val("post_rst_busy", 64'(busy), 64'd0);

    // Continuous instance: frame every 10 cycles, every channel reads 2
    for (int n = 0; n < 2000 && fv2_n < 6; n++) @(negedge clk);
    if (fv2_n < 6) check_val("cont_pulses", 64'(fv2_n), 64'd6);
    for (int i = 1; i < 6; i++) check_val($sformatf("cont_period%0d", i), 64'(fv2_t[i] - fv2_t[i-1]), 64'd10);
    for (int i = 0; i < 6; i++) check_val($sformatf("cont_ttd%0d", i), ttd2_c[i], {4{16'd2}});
    for (int i = 0; i < 6; i++) check_val($sformatf("cont_state%0d", i), 64'(st2_c[i]), 64'b100);
    check_val("cont_flags", 64'(timeout_flag2), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
